// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state, sel codes, flag layout and command type for the ALU op sequencer
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    MUL   = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] SEL_MUL     = 4'b1001;
  localparam logic [3:0] SEL_UNDEF_E = 4'b1110;
  localparam logic [3:0] SEL_UNDEF_F = 4'b1111;

  localparam int FLAG_COUT = 3;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 0;

  localparam logic [3:0] UNDEF_FLAGS = 4'b0010;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        cin;
  } cmd_t;

  function automatic logic sel_is_undef(input logic [3:0] sel);
    return (sel == SEL_UNDEF_E) || (sel == SEL_UNDEF_F);
  endfunction

  // Carry and overflow both mean "product does not fit in 32 bits".
  function automatic logic [3:0] mul_flags(input logic [63:0] product);
    logic [3:0] f;
    logic       hi;
    hi           = |product[63:32];
    f            = '0;
    f[FLAG_COUT] = hi;
    f[FLAG_NEG]  = product[31];
    f[FLAG_ZERO] = (product[31:0] == 32'd0);
    f[FLAG_OVF]  = hi;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// rtl/alu_seq_fifo.sv - synchronous command FIFO with full/empty, extra-bit pointers
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - buffered ALU front end with internal shift-add multiply
// Optional ALU_SEQ_PERF_EN adds perf_ops / perf_stall counters.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] MUL_SEL    = SEL_MUL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_sel,
  input  logic        cmd_cin,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  output logic        alu_cin,
  input  logic [31:0] alu_y,
  input  logic        alu_cout,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y,
  output logic [3:0]  rsp_flags,
`ifdef ALU_SEQ_PERF_EN
  output logic        busy,
  output logic [15:0] perf_ops,
  output logic [15:0] perf_stall
`else
  output logic        busy
`endif
);

  state_t      state;
  cmd_t        push_cmd;
  cmd_t        head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        issue_undef;
  logic [63:0] mul_mcand;
  logic [31:0] mul_mplier;
  logic [63:0] mul_acc;
  logic [4:0]  mul_cnt;
  logic [63:0] acc_next;
  logic [3:0]  alu_flags;

  assign push_cmd  = '{a: cmd_a, b: cmd_b, sel: cmd_sel, cin: cmd_cin};
  assign cmd_ready = rst_n && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  // A new command leaves the FIFO only when the FSM can start it this edge.
  assign pop       = !fifo_empty && ((state == IDLE) || ((state == RESP) && rsp_ready));
  assign busy      = rst_n && ((state != IDLE) || !fifo_empty);

  always_comb begin
    alu_flags            = '0;
    alu_flags[FLAG_COUT] = alu_cout;
    alu_flags[FLAG_NEG]  = alu_negative;
    alu_flags[FLAG_ZERO] = alu_zero;
    alu_flags[FLAG_OVF]  = alu_overflow;
  end

  assign acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : 64'd0);

  alu_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_y       <= '0;
      rsp_flags   <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      alu_cin     <= 1'b0;
      issue_undef <= 1'b0;
      mul_mcand   <= '0;
      mul_mplier  <= '0;
      mul_acc     <= '0;
      mul_cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
        end
        ISSUE: begin
          rsp_valid <= 1'b1;
          rsp_y     <= issue_undef ? 32'd0 : alu_y;
          rsp_flags <= issue_undef ? UNDEF_FLAGS : alu_flags;
          state     <= RESP;
        end
        MUL: begin
          mul_acc    <= acc_next;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + 5'd1;
          if (mul_cnt == 5'd31) begin
            rsp_valid <= 1'b1;
            rsp_y     <= acc_next[31:0];
            rsp_flags <= mul_flags(acc_next);
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase

      // Dispatch overrides the state chosen above, giving RESP -> ISSUE/MUL with no bubble.
      if (pop) begin
        if (head.sel == MUL_SEL) begin
          state      <= MUL;
          mul_mcand  <= {32'd0, head.a};
          mul_mplier <= head.b;
          mul_acc    <= '0;
          mul_cnt    <= '0;
        end else begin
          state       <= ISSUE;
          issue_undef <= sel_is_undef(head.sel);
          if (!sel_is_undef(head.sel)) begin
            alu_a   <= head.a;
            alu_b   <= head.b;
            alu_sel <= head.sel;
            alu_cin <= head.cin;
          end
        end
      end
    end
  end

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (rsp_valid && rsp_ready) perf_ops <= perf_ops + 16'd1;
      if (rsp_valid && !rsp_ready && (perf_stall != 16'hFFFF)) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule
